// File: rtl/multi_button_debouncer_if.sv
// Button bundle between the raw front-panel inputs and the debounced outputs.
// The master drives the raw levels; the slave (the debouncer) returns levels and strobes.
interface multi_button_debouncer_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] btn_in;
    logic [CHANNELS-1:0] btn_level;
    logic [CHANNELS-1:0] btn_rise;
    logic [CHANNELS-1:0] btn_fall;
    logic                any_event;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  any_event
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output any_event
    );
endinterface

// File: rtl/multi_button_debouncer.sv
// Debouncer for CHANNELS independent push buttons: both press and release are qualified,
// polarity is per channel, and one-cycle rise/fall strobes plus a combined event flag are produced.
module multi_button_debouncer #(
    parameter int                  CHANNELS   = 4,
    parameter int                  LIMIT      = 100000,
    parameter logic [CHANNELS-1:0] ACTIVE_LOW = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    multi_button_debouncer_if.slave  btn
);
    localparam int              CNT_W    = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] pressed_s;
    logic [CHANNELS-1:0] level_vec;
    logic [CHANNELS-1:0] rise_vec;
    logic [CHANNELS-1:0] fall_vec;
    logic                any_q;

    // The synchroniser carries raw levels so that reset can load each channel's inactive
    // pin level; polarity correction follows, giving the same timing as correcting up front.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= btn.btn_in;
            sync2 <= sync1;
        end
    end

    assign pressed_s = sync2 ^ ACTIVE_LOW;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= RELEASED;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            case (state_q)
                RELEASED: begin
                    if (pressed_s[i]) state_d = PRESS_WAIT;
                end
                PRESS_WAIT: begin
                    if (!pressed_s[i]) begin
                        state_d = RELEASED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = PRESSED;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!pressed_s[i]) state_d = RELEASE_WAIT;
                end
                RELEASE_WAIT: begin
                    if (pressed_s[i]) begin
                        state_d = PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = RELEASED;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = RELEASED;
            endcase
        end

        assign level_vec[i] = level_q;
        assign rise_vec[i]  = rise_q;
        assign fall_vec[i]  = fall_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) any_q <= 1'b0;
        else       any_q <= |(rise_vec | fall_vec);
    end

    assign btn.btn_level = level_vec;
    assign btn.btn_rise  = rise_vec;
    assign btn.btn_fall  = fall_vec;
    assign btn.any_event = any_q;
endmodule

// File: tb/tb_multi_button_debouncer.sv
// Bench for multi_button_debouncer: directed scenarios plus randomized hold/glitch stimulus,
// all checked against a stable-run-length reference model.
module tb_multi_button_debouncer;
    localparam int             CH    = 4;
    localparam int             LIMIT = 4;
    localparam logic [CH-1:0]  AL    = 4'b1000;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    multi_button_debouncer_if #(.CHANNELS(CH)) bif ();

    multi_button_debouncer #(
        .CHANNELS  (CH),
        .LIMIT     (LIMIT),
        .ACTIVE_LOW(AL)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .btn  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the polarity-corrected input reaches the decision point two edges late;
    // a channel flips once it has seen LIMIT+1 consecutive samples opposite to its level.
    logic [CH-1:0] m_d1, m_d2, m_level, m_rise, m_fall;
    logic          m_any;
    int            m_run [CH];

    always @(posedge clk or posedge reset) begin : model
        logic [CH-1:0] lvl, r, f;
        int            run [CH];
        if (reset) begin
            m_d1    <= '0;
            m_d2    <= '0;
            m_level <= '0;
            m_rise  <= '0;
            m_fall  <= '0;
            m_any   <= 1'b0;
            for (int i = 0; i < CH; i++) m_run[i] <= 0;
        end else begin
            lvl = m_level;
            r   = '0;
            f   = '0;
            for (int i = 0; i < CH; i++) begin
                run[i] = (m_d2[i] != lvl[i]) ? m_run[i] + 1 : 0;
                if (run[i] == LIMIT + 1) begin
                    lvl[i] = ~lvl[i];
                    if (lvl[i]) r[i] = 1'b1;
                    else        f[i] = 1'b1;
                    run[i] = 0;
                end
                m_run[i] <= run[i];
            end
            m_any   <= |(m_rise | m_fall);
            m_level <= lvl;
            m_rise  <= r;
            m_fall  <= f;
            m_d2    <= m_d1;
            m_d1    <= bif.btn_in ^ AL;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bif.btn_in = 4'b1000;
        #2;
        total++;
        if ({bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event});
        end
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if ({bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event} !== 13'd0) begin
                bad++;
                $display("FAIL idle_no_strobe cycle=%0d got=%b exp=0", c,
                         {bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event});
            end
        end
    endtask

    task automatic test_clean_press();
        bif.btn_in[0] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            total++;
            if ({bif.btn_rise[0], bif.btn_level[0], bif.any_event} !== {e == 6, e >= 6, e == 7}) begin
                bad++;
                $display("FAIL clean_press edge=%0d got rise/level/any=%b%b%b exp=%b%b%b", e,
                         bif.btn_rise[0], bif.btn_level[0], bif.any_event, e == 6, e >= 6, e == 7);
            end
            total++;
            if ({bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event} !== {m_level, m_rise, m_fall, m_any}) begin
                bad++;
                $display("FAIL clean_press_model edge=%0d got=%b exp=%b", e,
                         {bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event}, {m_level, m_rise, m_fall, m_any});
            end
        end
    endtask

    task automatic test_bounce_reject();
        int rises;
        rises = 0;
        for (int c = 0; c < 16; c++) begin
            bif.btn_in[1] = (c < 8) ? ((c / 2) % 2 == 0) : 1'b0;
            tick();
            if (bif.btn_rise[1]) rises++;
            total++;
            if ({bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event} !== {m_level, m_rise, m_fall, m_any}) begin
                bad++;
                $display("FAIL bounce_model cycle=%0d got=%b exp=%b", c,
                         {bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event}, {m_level, m_rise, m_fall, m_any});
            end
        end
        total++;
        if (rises !== 0 || bif.btn_level[1] !== 1'b0) begin
            bad++;
            $display("FAIL bounce_reject rises=%0d level1=%b exp rises=0 level1=0", rises, bif.btn_level[1]);
        end
    endtask

    task automatic test_release_debounce();
        int falls;
        int fall_edge;
        falls = 0;
        bif.btn_in[0] = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (c == 3) bif.btn_in[0] = 1'b1;
            tick();
            if (bif.btn_fall[0]) falls++;
        end
        total++;
        if (falls !== 0 || bif.btn_level[0] !== 1'b1) begin
            bad++;
            $display("FAIL release_glitch falls=%0d level0=%b exp falls=0 level0=1", falls, bif.btn_level[0]);
        end
        falls = 0;
        fall_edge = -1;
        bif.btn_in[0] = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (bif.btn_fall[0]) begin
                falls++;
                fall_edge = e;
            end
            total++;
            if ({bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event} !== {m_level, m_rise, m_fall, m_any}) begin
                bad++;
                $display("FAIL release_model edge=%0d got=%b exp=%b", e,
                         {bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event}, {m_level, m_rise, m_fall, m_any});
            end
        end
        total++;
        if (falls !== 1 || fall_edge !== 6) begin
            bad++;
            $display("FAIL release_fall falls=%0d edge=%0d exp falls=1 edge=6", falls, fall_edge);
        end
    endtask

    task automatic test_parallel_active_low();
        bif.btn_in[3] = 1'b0;
        bif.btn_in[2] = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            total++;
            if (bif.btn_rise[3:2] !== ((e == 6) ? 2'b11 : 2'b00)) begin
                bad++;
                $display("FAIL parallel_rise edge=%0d got=%b exp=%b", e, bif.btn_rise[3:2],
                         (e == 6) ? 2'b11 : 2'b00);
            end
        end
        total++;
        if (bif.btn_level !== 4'b1100) begin
            bad++;
            $display("FAIL parallel_level got=%b exp=1100", bif.btn_level);
        end
    endtask

    task automatic test_mid_reset();
        bif.btn_in[2] = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        bif.btn_in[2] = 1'b1;
        for (int e = 0; e < 5; e++) tick();
        total++;
        if (bif.btn_level !== 4'b1000) begin
            bad++;
            $display("FAIL pre_reset_level got=%b exp=1000", bif.btn_level);
        end
        #1 reset = 1'b1;
        #1;
        total++;
        if ({bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event} !== 13'd0) begin
            bad++;
            $display("FAIL async_reset_clear got=%b exp=0", {bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event});
        end
        #1 reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            total++;
            if (bif.btn_rise[3:2] !== ((e == 6) ? 2'b11 : 2'b00) || bif.btn_fall !== 4'b0000) begin
                bad++;
                $display("FAIL mid_reset_requalify edge=%0d got rise=%b fall=%b exp rise=%b fall=0000", e,
                         bif.btn_rise[3:2], bif.btn_fall, (e == 6) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] pins;
        int            hold;
        int            seg_bad;
        seg_bad = 0;
        for (int s = 0; s < 60; s++) begin
            pins = CH'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 10);
            bif.btn_in = pins;
            for (int c = 0; c < hold; c++) begin
                tick();
                total++;
                if ({bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event} !== {m_level, m_rise, m_fall, m_any}) begin
                    bad++;
                    seg_bad++;
                    if (seg_bad <= 10)
                        $display("FAIL random_model seg=%0d cycle=%0d in=%b got=%b exp=%b", s, c, pins,
                                 {bif.btn_level, bif.btn_rise, bif.btn_fall, bif.any_event},
                                 {m_level, m_rise, m_fall, m_any});
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_clean_press();
        test_bounce_reject();
        test_release_debounce();
        test_parallel_active_low();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
